// File: rtl/prog_loader.sv
// Streams a header byte plus N program words from a byte source into a processor's program
// memory, one Addrload/PRload strobe pair per word.
module prog_loader (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       programEn,
    output logic       Addrload,
    output logic       PRload,
    output logic [4:0] AddrSel,
    output logic [7:0] prog_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWaitByte,
        StAddr,
        StWrite,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic [4:0] n_q, n_d;
    logic [7:0] data_q, data_d;
    logic       err_q, err_d;
    logic [4:0] last_addr;
    logic       xfer;

    assign xfer = in_valid & in_ready;
    // n_q == 0 encodes 32 words; the 5-bit wrap makes the last address 31.
    assign last_addr = n_q - 5'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            addr_q  <= 5'd0;
            n_q     <= 5'd0;
            data_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        n_d     = n_q;
        data_d  = data_q;
        err_d   = err_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StHdr;
                        err_d   = 1'b0;
                        addr_d  = 5'd0;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        if (in_data[7:5] != 3'd0) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            n_d     = in_data[4:0];
                            state_d = StWaitByte;
                        end
                    end
                end
                StWaitByte: begin
                    if (xfer) begin
                        data_d  = in_data;
                        state_d = StAddr;
                    end
                end
                StAddr: state_d = StWrite;
                StWrite: begin
                    if (addr_q == last_addr) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 5'd1;
                        state_d = StWaitByte;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // All handshake and strobe outputs come straight from registered state.
    assign in_ready  = (state_q == StHdr) || (state_q == StWaitByte);
    assign programEn = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign Addrload  = (state_q == StAddr);
    assign PRload    = (state_q == StWrite);
    assign done      = (state_q == StDone);
    assign AddrSel   = addr_q;
    assign prog_data = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of loads, hand-written abort/reset sequences, and random loads
// checked against a write-list model derived from the header rules.
module tb_prog_loader;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       programEn;
    logic       Addrload;
    logic       PRload;
    logic [4:0] AddrSel;
    logic [7:0] prog_data;
    logic       busy;
    logic       done;
    logic       err;

    always #5 Clock = ~Clock;

    prog_loader dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .programEn (programEn),
        .Addrload  (Addrload),
        .PRload    (PRload),
        .AddrSel   (AddrSel),
        .prog_data (prog_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0] hdr;
        int         gap;
        logic [7:0] base;
        logic [7:0] step;
        logic       exp_err;
        int         exp_n;
    } vec_t;

    vec_t        tbl[8];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          viol_cnt = 0;
    logic [12:0] wr_q[$];
    logic        prev_al = 1'b0;
    logic [4:0]  prev_addr = 5'd0;
    logic [7:0]  prev_data = 8'd0;
    logic [7:0]  tx[32];

    always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

    // Observes every cycle: logs writes, counts done pulses, flags protocol breaches.
    always @(negedge Clock) begin
        if (!Reset) begin
            prev_al <= 1'b0;
        end else begin
            if ((Addrload && PRload) || ((Addrload || PRload || done || in_ready) && !programEn)
                || (busy != programEn)) begin
                viol_cnt <= viol_cnt + 1;
                $display("protocol violation (strobes/enables) at cycle %0d", cyc_cnt);
            end
            if (PRload) begin
                if (!prev_al || prev_addr !== AddrSel || prev_data !== prog_data) begin
                    viol_cnt <= viol_cnt + 1;
                    $display("protocol violation (PRload without matching Addrload) at cycle %0d",
                             cyc_cnt);
                end
                wr_q.push_back({AddrSel, prog_data});
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc_cnt;
            end
            prev_al   <= Addrload;
            prev_addr <= AddrSel;
            prev_data <= prog_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {in_ready, programEn, Addrload, PRload, AddrSel, prog_data, busy, done, err},
              32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge Clock);
            ok = in_ready;
            @(posedge Clock);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge Clock);
            idle = !busy;
        end
        check("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    // Expected writes are (i, tx[i]) for i < exp_n.
    task automatic run_load(input logic [7:0] hdr, input int gap, input logic exp_err,
                            input int exp_n, input bit rnd_start);
        int wbase;
        int dbase;
        int scyc;
        bit ok;
        @(posedge Clock);
        #1;
        wbase = wr_q.size();
        dbase = done_cnt;
        start = 1'b1;
        scyc  = cyc_cnt;
        @(posedge Clock);
        #1;
        start = 1'b0;
        check("err_clear", {31'd0, err}, 32'd0);
        send_byte(hdr, 1'b0, ok);
        for (int i = 0; i < exp_n && ok; i++) begin
            repeat (gap) @(posedge Clock);
            if (gap > 0) #1;
            send_byte(tx[i], rnd_start && ($urandom_range(0, 3) == 0), ok);
        end
        wait_idle();
        check("write_count", wr_q.size() - wbase, exp_n);
        for (int i = 0; i < exp_n && (wbase + i) < wr_q.size(); i++)
            check("write_word", {19'd0, wr_q[wbase + i]}, {19'd0, 5'(i), tx[i]});
        check("err_flag", {31'd0, err}, {31'd0, exp_err});
        check("done_count", done_cnt - dbase, exp_err ? 0 : 1);
        if (gap == 0 && !exp_err && ok)
            check("load_cycles", done_cyc - scyc, 2 + 3 * exp_n);
    endtask

    initial begin
        bit         ok;
        bit         hit;
        int         wbase;
        int         dbase;
        logic [7:0] hdr;
        logic       m_err;
        int         m_n;

        Reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        tbl[0] = '{8'h03, 0, 8'hA1, 8'h11, 1'b0, 3};
        tbl[1] = '{8'h00, 0, 8'h00, 8'h01, 1'b0, 32};
        tbl[2] = '{8'h25, 0, 8'h00, 8'h01, 1'b1, 0};
        tbl[3] = '{8'h02, 5, 8'h5A, 8'h33, 1'b0, 2};
        tbl[4] = '{8'h01, 1, 8'hFF, 8'h01, 1'b0, 1};
        tbl[5] = '{8'h1F, 0, 8'h80, 8'h03, 1'b0, 31};
        tbl[6] = '{8'h10, 2, 8'h20, 8'h07, 1'b0, 16};
        tbl[7] = '{8'h20, 0, 8'h00, 8'h01, 1'b1, 0};

        repeat (2) @(negedge Clock);
        check_all_zero("reset_outputs");
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        check("idle_after_release", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 32; j++) tx[j] = 8'(tbl[v].base + tbl[v].step * j);
            run_load(tbl[v].hdr, tbl[v].gap, tbl[v].exp_err, tbl[v].exp_n, 1'b0);
        end

        // err is set here; abort must beat start and leave it alone.
        @(posedge Clock);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", {30'd0, busy, err}, 32'd1);

        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("idle_no_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge Clock);
        #1;
        in_valid = 1'b0;

        // Abort while word 1 of 4 is being written.
        for (int j = 0; j < 32; j++) tx[j] = 8'(8'h10 + j);
        wbase = wr_q.size();
        dbase = done_cnt;
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        send_byte(8'h04, 1'b0, ok);
        send_byte(tx[0], 1'b0, ok);
        send_byte(tx[1], 1'b0, ok);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge Clock);
            hit = PRload && (AddrSel == 5'd1);
        end
        check("abort_reached_write", {31'd0, hit}, 32'd1);
        abort = 1'b1;
        @(posedge Clock);
        #1;
        abort = 1'b0;
        check("abort_idle", {30'd0, busy, programEn}, 32'd0);
        in_valid = 1'b1;
        in_data  = tx[2];
        repeat (8) @(posedge Clock);
        #1;
        in_valid = 1'b0;
        check("abort_writes", wr_q.size() - wbase, 2);
        check("abort_no_done", done_cnt - dbase, 0);

        // Asynchronous reset while in ADDR.
        for (int j = 0; j < 32; j++) tx[j] = 8'(8'h40 + j);
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        send_byte(8'h03, 1'b0, ok);
        send_byte(tx[0], 1'b0, ok);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge Clock);
            hit = Addrload;
        end
        check("reset_reached_addr", {31'd0, hit}, 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("idle_until_start", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 32; j++) tx[j] = 8'(8'h70 + j);
        run_load(8'h03, 0, 1'b0, 3, 1'b0);

        for (int r = 0; r < 20; r++) begin
            hdr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255))
                                              : 8'($urandom_range(0, 31));
            for (int j = 0; j < 32; j++) tx[j] = 8'($urandom_range(0, 255));
            m_err = (hdr >= 8'd32);
            m_n   = m_err ? 0 : (((hdr % 32) == 0) ? 32 : int'(hdr % 32));
            run_load(hdr, $urandom_range(0, 2), m_err, m_n, 1'b1);
        end

        check("protocol_invariants", viol_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: Reset  in  1  asynchronous, active-low; clears all state immediately, independent of Clock.
REQ-003 SHALL have: start  in  1  one-cycle request to begin a program load; sampled only in IDLE.
REQ-004 SHALL have: abort  in  1  cancel an in-progress load; highest priority after Reset.
REQ-005 SHALL have: in_valid  in  1  byte-stream source has a byte on in_data.
REQ-006 SHALL have: in_data  in  8  byte-stream payload (header byte, then program words).
REQ-007 SHALL have: in_ready  out  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-008 SHALL have: programEn  out  1  processor program-mode enable; high for the whole load.
REQ-009 SHALL have: Addrload  out  1  one-cycle strobe; processor latches AddrSel into its program address register.
REQ-010 SHALL have: PRload  out  1  one-cycle strobe; processor writes prog_data into memory at the latched address.
REQ-011 SHALL have: AddrSel  out  5  program memory address, 0..31.
REQ-012 SHALL have: prog_data  out  8  word to be written; drives the processor's 8-bit Input bus.
REQ-013 SHALL have: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have: done  out  1  one-cycle pulse on successful completion.
REQ-015 SHALL have: err  out  1  sticky header-error flag; cleared by the next accepted start or by Reset.

Function
REQ-016 SHALL implement states IDLE, HDR, WAIT_BYTE, ADDR, WRITE, DONE.
REQ-017 IDLE: in_ready=0, programEn=0; start=1 -> HDR, clear err.
REQ-018 HDR: in_ready=1, programEn=1; on transfer, in_data[7:5]!=0 -> set err, go IDLE; else N = in_data[4:0], with 0 meaning 32; go WAIT_BYTE.
REQ-019 WAIT_BYTE: in_ready=1; on transfer, latch in_data into prog_data; go ADDR.
REQ-020 ADDR: Addrload=1 for exactly one cycle with AddrSel=current address; go WRITE.
REQ-021 WRITE: PRload=1 for exactly one cycle; AddrSel and prog_data held stable from ADDR.
REQ-022 WRITE exit: address == N-1 -> DONE; else address+1 -> WAIT_BYTE.
REQ-023 Word latency: byte accepted at edge k -> Addrload high cycle k+1 -> PRload high cycle k+2 -> in_ready high again cycle k+3; maximum throughput is 1 word / 3 cycles.
REQ-024 Address SHALL start at 0 on every load and be 5 bits; N=32 completes at address 31 with no wrap to 0.
REQ-025 DONE: done=1 and programEn=1 for one cycle; go IDLE.
REQ-026 Addrload and PRload SHALL never be high in the same cycle, and SHALL be 0 whenever programEn=0.
REQ-027 in_ready SHALL be 0 in ADDR, WRITE, DONE and IDLE; in_valid in those states is ignored and the byte is not consumed.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next edge, drop programEn, suppress done, leave err unchanged; words already written stay written.
REQ-030 abort and start in the same IDLE cycle: abort wins; remain IDLE.
REQ-031 Strobes and in_ready SHALL be decoded from registered state only, with no combinational path from in_valid to in_ready.

Reset
REQ-032 Reset=0 SHALL force IDLE, address=0, N=0, prog_data=0, AddrSel=0, err=0, with all outputs 0, asynchronously.
REQ-033 Reset asserted mid-load SHALL drop programEn, Addrload and PRload without waiting for Clock; after release the block remains in IDLE until start.

Verification
REQ-034 Header 0x03, words 0xA1,0xB2,0xC3 with in_valid always high -> Addrload/PRload pairs at AddrSel 0,1,2 with data A1,B2,C3; done pulses once; 1+3*3+1 cycles from start.
REQ-035 Header 0x00, then 32 bytes 0x00..0x1F -> 32 writes, last at AddrSel=31, then done; no write to address 0 after address 31.
REQ-036 Header 0x25 -> err=1, no Addrload/PRload pulses, returns to IDLE; the next start clears err.
REQ-037 Header 0x02, in_valid gapped 5 cycles between bytes -> in_ready stays high through the gap, exactly 2 writes, prog_data stable across ADDR and WRITE.
REQ-038 abort asserted during WRITE of word 1 of 4 -> IDLE next cycle, programEn=0, no done, no further strobes.
REQ-039 Reset pulled low during ADDR -> all outputs 0 before the next Clock edge; start after release performs a clean load from address 0.
